// File: rtl/audio_avg_filter_if.sv
// Codec-side handshake bundle for the moving-average audio filter.
// The filter takes the master view; the codec (or a bench) takes the slave view.
interface audio_avg_filter_if #(
   parameter int DATA_W = 24
);
   logic              read_ready;
   logic              write_ready;
   logic [DATA_W-1:0] readdata_left;
   logic [DATA_W-1:0] readdata_right;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata_left;
   logic [DATA_W-1:0] writedata_right;

   modport master (
      input  read_ready, write_ready, readdata_left, readdata_right,
      output read, write, writedata_left, writedata_right
   );

   modport slave (
      output read_ready, write_ready, readdata_left, readdata_right,
      input  read, write, writedata_left, writedata_right
   );
endinterface

// File: rtl/audio_avg_filter.sv
// Stereo 2^DEPTH_LOG2-tap moving-average filter sitting between codec read and write ports.
// Optional macro AUDIO_FILTER_BYPASS_EN adds a bypass input that forwards raw samples.
module audio_avg_filter #(
   parameter int DATA_W     = 24,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic               CLOCK_50,
   input  logic               reset,
`ifdef AUDIO_FILTER_BYPASS_EN
   input  logic               bypass,
`endif
   audio_avg_filter_if.master codec
);
   localparam int N     = 1 << DEPTH_LOG2;
   localparam int SUM_W = DATA_W + DEPTH_LOG2;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      ACCUM,
      WAIT_WR,
      WRITE
   } state_t;

   state_t state, state_nxt;

   logic signed [DATA_W-1:0] cap_l_p0, cap_r_p0;
   logic signed [DATA_W-1:0] hist_l [N];
   logic signed [DATA_W-1:0] hist_r [N];
   logic signed [SUM_W-1:0]  sum_l_p1, sum_r_p1;
   logic signed [SUM_W-1:0]  sum_l_nxt, sum_r_nxt;
   logic [DEPTH_LOG2-1:0]    ptr;
   logic signed [DATA_W-1:0] out_l_p2, out_r_p2;
   logic                     sel_raw;

   function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] x);
      return {{DEPTH_LOG2{x[DATA_W-1]}}, x};
   endfunction

   // Arithmetic shift floors toward -inf; the result always fits back in DATA_W bits.
   function automatic logic signed [DATA_W-1:0] avg_trunc(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] q;
      q = s >>> DEPTH_LOG2;
      return q[DATA_W-1:0];
   endfunction

`ifdef AUDIO_FILTER_BYPASS_EN
   assign sel_raw = bypass;
`else
   assign sel_raw = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      codec.read  = 1'b0;
      codec.write = 1'b0;
      unique case (state)
         IDLE: begin
            if (codec.read_ready) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            codec.read = 1'b1;
            state_nxt  = ACCUM;
         end
         ACCUM: begin
            state_nxt = WAIT_WR;
         end
         WAIT_WR: begin
            if (codec.write_ready) state_nxt = WRITE;
         end
         WRITE: begin
            codec.write = 1'b1;
            state_nxt   = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Running sum replaces the oldest window entry with the newly captured sample.
   always_comb begin
      sum_l_nxt = sum_l_p1 + sext(cap_l_p0) - sext(hist_l[ptr]);
      sum_r_nxt = sum_r_p1 + sext(cap_r_p0) - sext(hist_r[ptr]);
   end

   // p0: sample capture
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cap_l_p0 <= '0;
         cap_r_p0 <= '0;
      end else if (state == CAPTURE) begin
         cap_l_p0 <= codec.readdata_left;
         cap_r_p0 <= codec.readdata_right;
      end
   end

   // p1/p2: window update and output load, both on the ACCUM edge
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sum_l_p1 <= '0;
         sum_r_p1 <= '0;
         ptr      <= '0;
         out_l_p2 <= '0;
         out_r_p2 <= '0;
         for (int i = 0; i < N; i++) begin
            hist_l[i] <= '0;
            hist_r[i] <= '0;
         end
      end else if (state == ACCUM) begin
         sum_l_p1    <= sum_l_nxt;
         sum_r_p1    <= sum_r_nxt;
         hist_l[ptr] <= cap_l_p0;
         hist_r[ptr] <= cap_r_p0;
         ptr         <= ptr + 1'b1;
         out_l_p2    <= sel_raw ? cap_l_p0 : avg_trunc(sum_l_nxt);
         out_r_p2    <= sel_raw ? cap_r_p0 : avg_trunc(sum_r_nxt);
      end
   end

   assign codec.writedata_left  = out_l_p2;
   assign codec.writedata_right = out_r_p2;

endmodule

// File: tb/tb_audio_avg_filter.sv
// Bench for audio_avg_filter: queue scoreboard fed by a window-average reference model,
// directed corner cases followed by randomized samples and write_ready stalls.
module tb_audio_avg_filter;
   localparam int DATA_W     = 24;
   localparam int DEPTH_LOG2 = 3;
   localparam int N          = 1 << DEPTH_LOG2;
   localparam int MAXV       = (1 << (DATA_W - 1)) - 1;
   localparam int MINV       = -(1 << (DATA_W - 1));

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;
`ifdef AUDIO_FILTER_BYPASS_EN
   logic bypass   = 1'b0;
`endif

   audio_avg_filter_if #(.DATA_W(DATA_W)) codec ();

   audio_avg_filter #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
`ifdef AUDIO_FILTER_BYPASS_EN
      .bypass  (bypass),
`endif
      .codec   (codec)
   );

   int                n_cmp = 0;
   int                n_bad = 0;
   longint            cyc = 0;
   longint            last_read_cyc = 0;
   bit                have_prev = 1'b0;
   bit                wr_rand = 1'b0;
   bit                wr_force = 1'b1;
   bit                lat_check = 1'b0;
   bit                prev_wr = 1'b0;
   logic [DATA_W-1:0] exp_l [$];
   logic [DATA_W-1:0] exp_r [$];
   longint            win_l [$];
   longint            win_r [$];

   initial forever #5 CLOCK_50 = ~CLOCK_50;
   initial forever begin
      @(posedge CLOCK_50);
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // Reference model: the last N samples (zeros before the window fills), averaged with floor.
   function automatic longint floor_div(input longint s);
      longint q;
      q = s / N;
      if ((s % N) != 0 && s < 0) q -= 1;
      return q;
   endfunction

   task automatic model_reset();
      win_l.delete();
      win_r.delete();
      for (int i = 0; i < N; i++) begin
         win_l.push_back(0);
         win_r.push_back(0);
      end
      exp_l.delete();
      exp_r.delete();
   endtask

   task automatic model_push(input int l, input int r);
      longint sl = 0;
      longint sr = 0;
      win_l.push_back(l);
      win_r.push_back(r);
      void'(win_l.pop_front());
      void'(win_r.pop_front());
      foreach (win_l[i]) sl += win_l[i];
      foreach (win_r[i]) sr += win_r[i];
      exp_l.push_back(DATA_W'(floor_div(sl)));
      exp_r.push_back(DATA_W'(floor_div(sr)));
   endtask

   initial begin
      codec.write_ready = 1'b0;
      forever begin
         @(posedge CLOCK_50);
         #1;
         codec.write_ready = wr_rand ? 1'($urandom_range(0, 1)) : wr_force;
      end
   end

   initial forever begin
      @(negedge CLOCK_50);
      if (codec.write) begin
         check("read_write_exclusive", longint'(codec.read), 0);
         check("write_single_cycle", longint'(prev_wr), 0);
         if (exp_l.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got write pulse, required none at cycle %0d", cyc);
         end else begin
            logic [DATA_W-1:0] el, er;
            el = exp_l.pop_front();
            er = exp_r.pop_front();
            check("writedata_left", longint'(codec.writedata_left), longint'(el));
            check("writedata_right", longint'(codec.writedata_right), longint'(er));
            if (lat_check) check("read_to_write_latency", cyc - last_read_cyc, 3);
         end
      end
      prev_wr = codec.write;
   end

   task automatic send(input int l, input int r, input bit expect_out, input bit keep_ready);
      bit got = 1'b0;
      @(negedge CLOCK_50);
      codec.readdata_left  = DATA_W'(l);
      codec.readdata_right = DATA_W'(r);
      codec.read_ready     = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge CLOCK_50);
         if (codec.read) got = 1'b1;
      end
      if (!keep_ready) codec.read_ready = 1'b0;
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL read_timeout: got no read pulse, required one within 200 cycles");
         return;
      end
      if (lat_check && have_prev)
         check("read_to_read_spacing_ge5", longint'((cyc - last_read_cyc) >= 5), 1);
      last_read_cyc = cyc;
      have_prev     = 1'b1;
      if (expect_out) model_push(l, r);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_l.size() > 0; i++) @(negedge CLOCK_50);
      check("drain_pending_writes", longint'(exp_l.size()), 0);
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset = 1'b1;
      #2;
      check("reset_read", longint'(codec.read), 0);
      check("reset_write", longint'(codec.write), 0);
      check("reset_writedata_left", longint'(codec.writedata_left), 0);
      check("reset_writedata_right", longint'(codec.writedata_right), 0);
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b0;
      model_reset();
      have_prev = 1'b0;
   endtask

   function automatic int rand_sample();
      int v;
      case ($urandom_range(0, 5))
         0:       v = MAXV;
         1:       v = MINV;
         2:       v = int'($urandom_range(0, 15)) - 8;
         default: begin
            v = int'($urandom_range(0, (1 << DATA_W) - 1));
            if (v > MAXV) v -= (1 << DATA_W);
         end
      endcase
      return v;
   endfunction

   initial begin
      codec.read_ready     = 1'b0;
      codec.readdata_left  = '0;
      codec.readdata_right = '0;

      do_reset();

      // Ramp up then evict: 800 x8, then 0 x8, with latency checks on the fast path
      lat_check = 1'b1;
      for (int i = 0; i < N; i++) send(800, -800, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) send(0, 0, 1'b1, 1'b0);
      drain();
      lat_check = 1'b0;

      // Floor toward -inf on a single -1 sample
      do_reset();
      send(-1, -1, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) send(0, 0, 1'b1, 1'b0);
      drain();

      // Full-scale positive then full-scale negative
      do_reset();
      for (int i = 0; i < N; i++) send(MAXV, MINV, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) send(MINV, MAXV, 1'b1, 1'b0);
      drain();

      // write_ready stall with read_ready kept high
      do_reset();
      wr_force = 1'b0;
      send(123, -456, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLOCK_50);
         check("stall_read_low", longint'(codec.read), 0);
         check("stall_write_low", longint'(codec.write), 0);
      end
      wr_force = 1'b1;
      @(negedge CLOCK_50);
      check("write_not_before_ready", longint'(codec.write), 0);
      @(negedge CLOCK_50);
      check("write_after_ready", longint'(codec.write), 1);
      codec.read_ready = 1'b0;
      drain();

      // Reset during WAIT_WR aborts the sample and empties the window
      do_reset();
      send(800, 800, 1'b1, 1'b0);
      drain();
      wr_force = 1'b0;
      @(negedge CLOCK_50);
      send(808, 8, 1'b0, 1'b0);
      repeat (2) @(negedge CLOCK_50);
      do_reset();
      wr_force = 1'b1;
      send(800, -800, 1'b1, 1'b0);
      drain();

      // Randomized samples with random idle gaps and write_ready stalls
      do_reset();
      wr_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
         send(rand_sample(), rand_sample(), 1'b1, 1'b0);
      end
      wr_rand  = 1'b0;
      wr_force = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/audio_avg_filter.md
AUDIO_AVG_FILTER -- requirements
Module: audio_avg_filter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, meaning the sample width per channel (two's complement).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of the averaging window N (N = 8).
REQ-003 The block SHALL have port CLOCK_50  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port read_ready  input  1  codec has a sample pair available.
REQ-006 The block SHALL have port write_ready  input  1  codec can accept a sample pair.
REQ-007 The block SHALL have ports readdata_left / readdata_right  input  DATA_W  samples from the codec.
REQ-008 The block SHALL have port read  output  1  one-cycle pulse consuming the codec sample pair.
REQ-009 The block SHALL have port write  output  1  one-cycle pulse delivering writedata to the codec.
REQ-010 The block SHALL have ports writedata_left / writedata_right  output  DATA_W  filtered samples to the codec.

Function
REQ-011 The FSM SHALL have states IDLE, CAPTURE, ACCUM, WAIT_WR, WRITE, all registered.
REQ-012 IDLE SHALL go to CAPTURE when read_ready=1, otherwise stay in IDLE.
REQ-013 CAPTURE SHALL assert read=1 for exactly that cycle, latch both readdata channels, and go to ACCUM unconditionally.
REQ-014 ACCUM SHALL, per channel: sum <= sum + new - buf[ptr]; buf[ptr] <= new; ptr <= ptr+1 modulo N (wraps N-1 -> 0); then go to WAIT_WR.
REQ-015 Each running sum SHALL be signed, DATA_W+DEPTH_LOG2 bits wide, so full-scale input never overflows.
REQ-016 On leaving ACCUM, writedata_* SHALL load sum >>> DEPTH_LOG2 (arithmetic shift, floor toward -inf), truncated to DATA_W bits, and hold until the next ACCUM.
REQ-017 WAIT_WR SHALL go to WRITE when write_ready=1; otherwise it SHALL stay, with read=0 regardless of read_ready.
REQ-018 WRITE SHALL assert write=1 for exactly that cycle and return to IDLE.
REQ-019 read and write SHALL never be asserted in the same cycle; each is high for at most one cycle per sample.
REQ-020 Minimum latency SHALL be: read pulse at cycle t, write pulse at t+3, next read pulse no earlier than t+5.
REQ-021 read_ready arriving during ACCUM/WAIT_WR/WRITE SHALL not be consumed until the FSM is back in IDLE.
REQ-022 Before N samples are received, the empty buffer slots SHALL contribute zero (startup ramp).

Reset
REQ-023 Asserting reset SHALL immediately force state=IDLE, read=0, write=0, writedata_*=0, both sums=0, ptr=0, and all buffer entries=0.
REQ-024 Reset asserted mid-operation (any state) SHALL abort the sample with no write pulse; after release the block SHALL restart from an empty window.

Configuration
REQ-025 When macro AUDIO_FILTER_BYPASS_EN is defined, the block SHALL add input port bypass (1 bit), and with bypass=1 writedata_* SHALL load the raw captured sample instead of the average; the buffer and sums SHALL still update, and handshake timing SHALL be unchanged.
REQ-026 When AUDIO_FILTER_BYPASS_EN is undefined, the bypass port SHALL not exist and the output SHALL always be the average.

Verification
REQ-027 Reset, then 8 samples L=800, R=-800 with both readies high -> writedata_left = 100,200,...,800 and writedata_right = -100,...,-800 on successive writes.
REQ-028 After REQ-027, 8 samples L=0, R=0 -> left 700,600,...,0 and right -700,...,0, proving wrap and eviction of the oldest sample.
REQ-029 Reset, then one sample L=-1 followed by zeros -> first output -1 (floor); 8th output -1; 9th output 0.
REQ-030 Reset, then 8 samples of 0x7FFFFF and then 8 of 0x800000 -> 8th output 0x7FFFFF, 16th output 0x800000, with no overflow wrap.
REQ-031 write_ready held low 5 cycles after ACCUM while read_ready is high -> state stays WAIT_WR, read=0 throughout, one write pulse in the cycle after write_ready rises.
REQ-032 Reset pulsed during WAIT_WR -> no write pulse, outputs 0; the next sample L=800 -> output 100.
